ram_nxm: RTL and testbench
==========================

RAM_NXM -- requirements
Module: ram_nxm

Interface
REQ-001 Parameter WIDTH, default 4: bits per word, legal range 1 to 32.
REQ-002 Parameter DEPTH, default 4: number of words, legal range 2 to 256, need not be a power of 2.
REQ-003 Derived constant AW = clog2(DEPTH): address width.
REQ-004 clk  input  1: clock; all state changes on its rising edge, except reset.
REQ-005 preset  input  1: reset, asynchronous, active-high.
REQ-006 en  input  1: access request, sampled each rising clk edge.
REQ-007 rw  input  1: access type; 1 = write, 0 = read.
REQ-008 addr  input  AW: word address.
REQ-009 data_in  input  WIDTH: write data.
REQ-010 clr_req  input  1: request to sweep-clear the whole array.
REQ-011 data_out  output  WIDTH: registered read data.
REQ-012 rd_valid  output  1: one-cycle pulse, data_out updated by a read.
REQ-013 busy  output  1: high while a sweep-clear is in progress.
REQ-014 addr_err  output  1: one-cycle pulse, access addressed a word >= DEPTH.

Function
REQ-015 Storage SHALL be DEPTH x WIDTH, held in flip-flops, with no tri-state outputs.
REQ-016 Write: en=1, rw=1, busy=0, clr_req=0, addr<DEPTH -> mem[addr] <= data_in at the edge; data_out and rd_valid unchanged.
REQ-017 Read: en=1, rw=0, busy=0, clr_req=0, addr<DEPTH -> data_out <= mem[addr] at the edge; rd_valid=1 for the following cycle; latency is 1 cycle.
REQ-018 data_out SHALL hold its last value until the next read or reset.
REQ-019 Same-address read/write collisions cannot occur, since there is a single port; back-to-back write then read of the same address SHALL return the new data.
REQ-020 Out-of-range address (addr >= DEPTH, when DEPTH is not a power of 2): a write SHALL leave memory unchanged; a read SHALL set data_out=0 with rd_valid=1; both cases SHALL pulse addr_err for one cycle.
REQ-021 FSM states: IDLE and SWEEP.
REQ-022 IDLE with clr_req=1 -> SWEEP on the next edge, with an internal counter set to 0; clr_req SHALL take priority, and a same-cycle en access is dropped with no rd_valid and no addr_err.
REQ-023 In SWEEP, each edge SHALL write mem[counter] <= 0 and increment counter; the edge that writes word DEPTH-1 SHALL return the FSM to IDLE, so a sweep takes exactly DEPTH cycles.
REQ-024 busy SHALL be 1 exactly while the FSM is in SWEEP.
REQ-025 While busy=1, en and clr_req SHALL be ignored: no write, no rd_valid, no addr_err.
REQ-026 The first access accepted is on the edge after busy falls.
REQ-027 rd_valid and addr_err SHALL never be high for more than one consecutive cycle unless accesses are back-to-back.

Reset
REQ-028 preset=1 SHALL immediately, without waiting for a clock edge, force every memory word to all-ones, data_out=0, rd_valid=0, addr_err=0, busy=0, FSM=IDLE and counter=0.
REQ-029 preset asserted mid-sweep SHALL abort the sweep; all words become all-ones, including words already cleared.
REQ-030 While preset=1, all inputs SHALL be ignored; operation resumes on the first rising edge after preset falls.

Verification
REQ-031 Reset readback (WIDTH=4, DEPTH=4): pulse preset, then read addr 0..3 -> data_out=1111 each time, rd_valid pulsed one cycle after each read.
REQ-032 Write/read: write 1101 to addr 2 and 0110 to addr 1, then read 2 and 1 -> data_out=1101 and then 0110, each one cycle after its read.
REQ-033 Sweep: after writes, assert clr_req for one cycle -> busy high for exactly 4 cycles; a read request during busy gives no rd_valid; afterwards reads of addr 0..3 -> 0000.
REQ-034 Priority: clr_req=1 with en=1, rw=1, addr=3, data_in=1010 in IDLE -> write dropped, sweep runs, addr 3 reads 0000.
REQ-035 Out of range (WIDTH=8, DEPTH=6): write 0xAA to addr 6 -> addr_err pulse and memory unchanged; read addr 7 -> data_out=0x00, rd_valid=1, addr_err=1.
REQ-036 Reset mid-sweep (DEPTH=4): assert preset during the 2nd sweep cycle -> busy=0 immediately; all reads return 1111.

Source files
------------

// File: rtl/ram_nxm.sv
// ram_nxm: DEPTH x WIDTH flip-flop RAM with single access port, registered
// read data, out-of-range detection and a multi-cycle sweep-clear.
module ram_nxm #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             en,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_req,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             busy,
  output logic             addr_err
);

  localparam int unsigned   AW1     = AW + 1;
  localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range_c;
  logic [WIDTH-1:0] rd_word_c;

  // Address decode; words beyond DEPTH read back as zero.
  always_comb begin
    in_range_c = ({1'b0, addr} < DEPTH_W);
    rd_word_c  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (addr == AW'(i)) rd_word_c = mem[i];
    end
  end

  // Storage, access handling and IDLE/SWEEP control; preset fills the array with ones.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '1;
    end else begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            // clear request wins; any same-cycle access is dropped
            state <= SWEEP;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (en) begin
            addr_err <= !in_range_c;
            if (rw) begin
              for (int i = 0; i < int'(DEPTH); i++) begin
                if (addr == AW'(i)) mem[i] <= data_in;
              end
            end else begin
              data_out <= rd_word_c;
              rd_valid <= 1'b1;
            end
          end
        end
        SWEEP: begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (cnt == AW'(i)) mem[i] <= '0;
          end
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_nxm.sv
// tb_ram_nxm: drives a 4x4 and an 8x6 ram_nxm from one shared stimulus stream
// and compares both against a word-array reference model every cycle.
module tb_ram_nxm;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       en = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       clr_req = 1'b0;

  logic [3:0] a_dout;
  logic       a_rv, a_busy, a_ae;
  logic [7:0] b_dout;
  logic       b_rv, b_busy, b_ae;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 = 4x4 instance, index 1 = 8x6 instance
  logic [7:0] m_mem  [2][8];
  int         left   [2];
  logic [7:0] e_dout [2];
  logic       e_rv   [2];
  logic       e_ae   [2];

  ram_nxm #(.WIDTH(4), .DEPTH(4)) u_a (
    .clk(clk), .preset(preset), .en(en), .rw(rw), .addr(addr[1:0]),
    .data_in(data_in[3:0]), .clr_req(clr_req), .data_out(a_dout),
    .rd_valid(a_rv), .busy(a_busy), .addr_err(a_ae)
  );

  ram_nxm #(.WIDTH(8), .DEPTH(6)) u_b (
    .clk(clk), .preset(preset), .en(en), .rw(rw), .addr(addr),
    .data_in(data_in), .clr_req(clr_req), .data_out(b_dout),
    .rd_valid(b_rv), .busy(b_busy), .addr_err(b_ae)
  );

  always #5 clk = ~clk;

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic logic [7:0] mask_of(input int k);
    return (k == 0) ? 8'h0F : 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = (i < depth_of(k)) ? mask_of(k) : 8'h00;
      left[k]   = 0;
      e_dout[k] = 8'h00;
      e_rv[k]   = 1'b0;
      e_ae[k]   = 1'b0;
    end
  endtask

  // One clock edge of behaviour for instance k, using the currently applied inputs.
  task automatic model_step(input int k);
    int d;
    int a;
    d = depth_of(k);
    a = (k == 0) ? int'(addr[1:0]) : int'(addr);
    e_rv[k] = 1'b0;
    e_ae[k] = 1'b0;
    if (left[k] > 0) begin
      m_mem[k][d - left[k]] = 8'h00;
      left[k]--;
    end else if (clr_req) begin
      left[k] = d;
    end else if (en) begin
      if (a >= d) begin
        e_ae[k] = 1'b1;
        if (!rw) begin
          e_dout[k] = 8'h00;
          e_rv[k]   = 1'b1;
        end
      end else if (rw) begin
        m_mem[k][a] = data_in & mask_of(k);
      end else begin
        e_dout[k] = m_mem[k][a];
        e_rv[k]   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("a_dout", 32'(a_dout), 32'(e_dout[0]));
    check("a_rv",   32'(a_rv),   32'(e_rv[0]));
    check("a_ae",   32'(a_ae),   32'(e_ae[0]));
    check("a_busy", 32'(a_busy), 32'(left[0] > 0));
    check("b_dout", 32'(b_dout), 32'(e_dout[1]));
    check("b_rv",   32'(b_rv),   32'(e_rv[1]));
    check("b_ae",   32'(b_ae),   32'(e_ae[1]));
    check("b_busy", 32'(b_busy), 32'(left[1] > 0));
  endtask

  // Apply inputs, take one edge, advance the model and compare just after the edge.
  task automatic cyc(input logic e, input logic r, input logic [2:0] a,
                     input logic [7:0] d, input logic c);
    en      = e;
    rw      = r;
    addr    = a;
    data_in = d;
    clr_req = c;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  // Asynchronous reset: outputs must respond before any clock edge.
  task automatic do_reset();
    preset  = 1'b1;
    en      = 1'b1;
    clr_req = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    preset = 1'b0;
    en     = 1'b0;
  endtask

  initial begin
    int busy_n;
    do_reset();

    // reset readback: every word reads all-ones
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      check("rst_rd", 32'(a_dout), 32'hF);
      check("rst_rv", 32'(a_rv), 32'h1);
    end
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // write then read back, including back-to-back same address
    cyc(1'b1, 1'b1, 3'd2, 8'hDD, 1'b0);
    cyc(1'b1, 1'b1, 3'd1, 8'h66, 1'b0);
    cyc(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    check("wr_rd2", 32'(a_dout), 32'hD);
    cyc(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    check("wr_rd1", 32'(a_dout), 32'h6);
    cyc(1'b1, 1'b1, 3'd0, 8'h39, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    check("b2b", 32'(b_dout), 32'h39);

    // sweep: busy for exactly DEPTH cycles, reads during busy ignored
    busy_n = 0;
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (a_busy) busy_n++;
      cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    check("busy_len", 32'(busy_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      check("swp_rd", 32'(a_dout), 32'h0);
    end

    // clear request beats a same-cycle write
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 3'(i), 8'hF7, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 8'h5A, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    check("prio_rd", 32'(a_dout), 32'h0);

    // out-of-range accesses on the 8x6 instance
    cyc(1'b1, 1'b1, 3'd6, 8'hAA, 1'b0);
    check("oor_wr_ae", 32'(b_ae), 32'h1);
    cyc(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    check("oor_rd_d", 32'(b_dout), 32'h0);
    check("oor_rd_rv", 32'(b_rv), 32'h1);
    check("oor_rd_ae", 32'(b_ae), 32'h1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);

    // reset in the second sweep cycle aborts the sweep
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_reset();
    check("abort_busy", 32'(a_busy), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      check("abort_rd", 32'(b_dout), 32'hFF);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), 8'($urandom),
          ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
